iir_fb_mac: RTL and testbench

- Recursive (feedback, a-coefficient) half of the configurable IIR filter.
- Computes y[n] = x[n] − Σ_{k=1..N} a[k]·y[n−k] using one time-multiplexed multiply-accumulate unit over N cycles per sample.
- Sits downstream of the feed-forward stage in the analogue front-end filter chain and consumes that stage's output.
- Uses a valid/ready input handshake and a one-cycle output strobe.

---
 rtl/iir_fb_mac_pkg.sv | 28 ++
 rtl/iir_round_sat.sv | 39 +++
 rtl/iir_fb_mac.sv | 128 ++++++++++++
 tb/tb_iir_fb_mac.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_fb_mac_pkg.sv
// Shared definitions for the IIR filter stages.
// State encoding, width helpers and rounding constants.
package iir_fb_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Minimum rounding shift; round-half-up needs one fractional bit.
    localparam int MIN_FRAC = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    // Accumulator width with headroom for N products plus the input term.
    function automatic int acc_width(input int p, input int cw, input int n);
        return p + cw + clog2(n) + 2;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up, arithmetic shift and saturate.
// Purely combinational; shared by both IIR stages.
module iir_round_sat #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 16,
    parameter int FRAC  = 14
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] value,
    output logic                    sat
);
    localparam int EW = IN_W + 1;

    localparam logic signed [EW-1:0] HALF =
        {{(EW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [EW-1:0] MAXV =
        {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV =
        {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] r;

    // Add half an LSB, shift down, clamp to the output range.
    always_comb begin
        sum   = {din[IN_W-1], din} + HALF;
        r     = sum >>> FRAC;
        value = r[OUT_W-1:0];
        sat   = 1'b0;
        if (r > MAXV) begin
            value = MAXV[OUT_W-1:0];
            sat   = 1'b1;
        end else if (r < MINV) begin
            value = MINV[OUT_W-1:0];
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/iir_fb_mac.sv
// Feedback half of the IIR filter: y = x - sum a[k]*y[n-k].
// One shared MAC walks the N taps, then rounds and saturates.
import iir_fb_mac_pkg::*;

module iir_fb_mac #(
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14,
    parameter int N           = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [PRECISION-1:0] x,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [COEFF_WIDTH*N-1:0]    packed_a_coeffs,
    output logic signed [PRECISION-1:0] y,
    output logic                        y_valid,
    output logic                        y_sat
);
    localparam int ACC_W  = acc_width(PRECISION, COEFF_WIDTH, N);
    localparam int PROD_W = PRECISION + COEFF_WIDTH;
    localparam int KW     = clog2(N + 2);

    state_t state;
    state_t state_nx;

    logic        [KW-1:0]          k;
    logic signed [ACC_W-1:0]       acc;
    logic signed [PRECISION-1:0]   hist [1:N];
    logic signed [COEFF_WIDTH-1:0] coef [1:N];

    logic signed [PRECISION-1:0]   h_sel;
    logic signed [COEFF_WIDTH-1:0] c_sel;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       prod_ext;
    logic signed [ACC_W-1:0]       x_ext;
    logic signed [PRECISION-1:0]   rs_val;
    logic                          rs_sat;

    assign x_ready  = (state == IDLE);
    assign x_ext    = {{(ACC_W-PRECISION){x[PRECISION-1]}}, x} <<< COEFF_FRAC;
    assign prod     = h_sel * c_sel;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Select the history tap and coefficient for the current k.
    always_comb begin
        h_sel = '0;
        c_sel = '0;
        for (int i = 1; i <= N; i++) begin
            if (k == KW'(i)) begin
                h_sel = hist[i];
                c_sel = coef[i];
            end
        end
    end

    iir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (PRECISION),
        .FRAC  (COEFF_FRAC)
    ) u_round_sat (
        .din   (acc),
        .value (rs_val),
        .sat   (rs_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: accept, walk N taps, emit one result.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (x_valid) state_nx = MAC;
            MAC:     if (k == KW'(N)) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: load, multiply-accumulate, round and shift history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k       <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            y_sat   <= 1'b0;
            for (int i = 1; i <= N; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (x_valid) begin
                        acc <= x_ext;
                        k   <= KW'(1);
                        for (int i = 1; i <= N; i++) begin
                            coef[i] <=
                                packed_a_coeffs[(i-1)*COEFF_WIDTH +: COEFF_WIDTH];
                        end
                    end
                end
                MAC: begin
                    acc <= acc - prod_ext;
                    k   <= k + KW'(1);
                end
                OUT: begin
                    y       <= rs_val;
                    y_sat   <= rs_sat;
                    y_valid <= 1'b1;
                    hist[1] <= rs_val;
                    for (int i = N; i >= 2; i--) begin
                        hist[i] <= hist[i-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_fb_mac.sv
// Self-checking bench for iir_fb_mac (N=4, Q2.14 coefficients).
// Directed cases plus random samples against an arithmetic model.
module tb_iir_fb_mac;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] x = '0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [63:0]        a_pk = '0;
    logic signed [15:0] y;
    logic               y_valid;
    logic               y_sat;

    int total = 0;
    int bad   = 0;

    int ca [1:4];
    int mh [1:4];

    iir_fb_mac #(
        .PRECISION   (16),
        .COEFF_WIDTH (16),
        .COEFF_FRAC  (14),
        .N           (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .x               (x),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .packed_a_coeffs (a_pk),
        .y               (y),
        .y_valid         (y_valid),
        .y_sat           (y_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack();
        logic [63:0] p;
        p = '0;
        for (int i = 1; i <= 4; i++) p[(i-1)*16 +: 16] = 16'(ca[i]);
        return p;
    endfunction

    task automatic set_a(input int a1, input int a2, input int a3, input int a4);
        ca[1] = a1; ca[2] = a2; ca[3] = a3; ca[4] = a4;
        a_pk = pack();
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) mh[i] = 0;
    endtask

    // y[n] = x[n] - sum a[k]*y[n-k], Q2.14, round half up, clamp to int16.
    task automatic model(input int xv, output longint ey, output longint es);
        longint acc;
        longint r;
        acc = longint'(xv) * 16384;
        for (int i = 1; i <= 4; i++) acc -= longint'(ca[i]) * longint'(mh[i]);
        r  = (acc + 8192) >>> 14;
        es = 0;
        if (r > 32767) begin
            r  = 32767;
            es = 1;
        end else if (r < -32768) begin
            r  = -32768;
            es = 1;
        end
        for (int i = 4; i > 1; i--) mh[i] = mh[i-1];
        mh[1] = int'(r);
        ey = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        x_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Send one sample and check result, latency and busy window.
    // chg_cyc>0 rewrites a1 just before edge E(chg_cyc).
    task automatic send(input string tag, input int xv,
                        input int chg_cyc, input int chg_a1);
        longint ey;
        longint es;
        int     c;
        int     busy;
        longint yh;
        model(xv, ey, es);
        @(negedge clk);
        x = 16'(xv);
        x_valid = 1'b1;
        for (int w = 0; w < 50 && !x_ready; w++) @(negedge clk);
        chk({tag, "_ready"}, longint'(x_ready), 1);
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        c = 1;
        busy = 0;
        while (!y_valid && c < 30) begin
            if (!x_ready) busy++;
            if (c == chg_cyc) begin
                ca[1] = chg_a1;
                a_pk = pack();
            end
            @(negedge clk);
            c++;
        end
        chk({tag, "_valid"}, longint'(y_valid), 1);
        chk({tag, "_lat"}, longint'(c - 1), 5);
        chk({tag, "_busy"}, longint'(busy), 5);
        chk({tag, "_y"}, longint'(y), ey);
        chk({tag, "_sat"}, longint'(y_sat), es);
        yh = longint'(y);
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(y_valid), 0);
        chk({tag, "_hold"}, longint'(y), yh);
    endtask

    initial begin : main
        longint eq [$];
        longint sq [$];
        longint ey;
        longint es;
        int     xs [4];
        int     idx;
        int     nout;
        int     vcnt;

        // Reset state
        set_a(0, 0, 0, 0);
        do_reset();
        chk("rst_ready", longint'(x_ready), 1);
        chk("rst_y", longint'(y), 0);
        chk("rst_valid", longint'(y_valid), 0);
        chk("rst_sat", longint'(y_sat), 0);

        // Passthrough
        send("pass", 1000, 0, 0);

        // One-pole decay with x_valid held continuously
        do_reset();
        set_a(-8192, 0, 0, 0);
        xs = '{16384, 0, 0, 0};
        idx = 0;
        nout = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (y_valid) begin
                if (nout < eq.size()) begin
                    chk("decay_y", longint'(y), eq[nout]);
                    chk("decay_sat", longint'(y_sat), sq[nout]);
                end
                nout++;
            end
            if (x_ready && idx < 4) begin
                x = 16'(xs[idx]);
                x_valid = 1'b1;
                model(xs[idx], ey, es);
                eq.push_back(ey);
                sq.push_back(es);
                idx++;
            end else if (idx == 4) begin
                x_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("decay_count", longint'(nout), 4);
        chk("decay_last", longint'(y), 2048);

        // Saturation with an integrator
        do_reset();
        set_a(-16384, 0, 0, 0);
        send("sat_p0", 30000, 0, 0);
        send("sat_p1", 30000, 0, 0);
        send("sat_n0", -32768, 0, 0);
        send("sat_n1", -32768, 0, 0);
        send("sat_n2", -32768, 0, 0);

        // Rounding, half up on both signs
        do_reset();
        set_a(-8192, 0, 0, 0);
        send("rnd_p0", 3, 0, 0);
        send("rnd_p1", 0, 0, 0);
        do_reset();
        send("rnd_n0", -3, 0, 0);
        send("rnd_n1", 0, 0, 0);

        // Reset in the middle of a computation
        do_reset();
        send("mid_pre", 1000, 0, 0);
        @(negedge clk);
        x = 16'(1000);
        x_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (y_valid) vcnt++;
            @(negedge clk);
        end
        chk("mid_novalid", longint'(vcnt), 0);
        chk("mid_ready", longint'(x_ready), 1);
        send("mid_post", 500, 0, 0);

        // Coefficient snapshot
        do_reset();
        set_a(-8192, 0, 0, 0);
        send("snap0", 16384, 0, 0);
        send("snap1", 0, 2, 0);
        send("snap2", 0, 0, 0);

        // Random coefficients and samples
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 1; i <= 4; i++) begin
                if ($urandom_range(0, 3) == 0) ca[i] = 0;
                else ca[i] = int'($urandom_range(0, 12000)) - 6000;
            end
            a_pk = pack();
            for (int s = 0; s < 6; s++) begin
                send("rand", int'($urandom_range(0, 65535)) - 32768, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
